// File: rtl/rr_grant_sequencer_8_if.sv
// Requester-side bus of the round-robin grant sequencer.
// The sequencer connects through slave; requester agents connect through master.
interface rr_grant_sequencer_8_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output req, done,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  req, done,
    output gnt, gnt_idx, gnt_valid, timeout
  );
endinterface

// File: rtl/rr_grant_sequencer_8.sv
// Round-robin sequencer that shares one resource among 8 requesters.
// It produces a registered one-hot grant with its encoder index, and enforces an optional hold timeout.
module rr_grant_sequencer_8 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  rr_grant_sequencer_8_if.slave bus
);

  typedef enum logic {IDLE, OWN} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t           state, state_nx;
  logic [2:0]       ptr, ptr_nx;
  logic [CNT_W-1:0] hold_cnt, hold_nx;
  logic [7:0]       gnt_q, gnt_nx;
  logic [2:0]       idx_q, idx_nx;
  logic             valid_q, valid_nx;
  logic             to_q, to_nx;

  logic [2:0]       win;
  logic             found;
  logic             rel_user, rel_to;

  // The first set request bit, found by scanning circularly upward from ptr.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!found && bus.req[ptr + 3'(i)]) begin
        found = 1'b1;
        win   = ptr + 3'(i);
      end
    end
  end

  assign rel_user = bus.done || !bus.req[idx_q];
  assign rel_to   = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    hold_nx  = hold_cnt;
    gnt_nx   = gnt_q;
    idx_nx   = idx_q;
    valid_nx = valid_q;
    to_nx    = 1'b0;
    unique case (state)
      IDLE: begin
        gnt_nx   = '0;
        valid_nx = 1'b0;
        if (found) begin
          gnt_nx   = 8'b1 << win;
          idx_nx   = win;
          valid_nx = 1'b1;
          hold_nx  = '0;
          state_nx = OWN;
        end
      end
      OWN: begin
        if (rel_user || rel_to) begin
          gnt_nx   = '0;
          valid_nx = 1'b0;
          state_nx = IDLE;
          ptr_nx   = idx_q + 3'd1;
          // A timeout is reported only when no owner-side release happens in the same cycle.
          to_nx    = !rel_user;
        end else if (hold_cnt != '1) begin
          hold_nx = hold_cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt_q    <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      hold_cnt <= hold_nx;
      gnt_q    <= gnt_nx;
      idx_q    <= idx_nx;
      valid_q  <= valid_nx;
      to_q     <= to_nx;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = valid_q;
  assign bus.timeout   = to_q;

endmodule

// File: doc/rr_grant_sequencer_8.md
Name: rr_grant_sequencer_8

Overview:
- Round-robin arbiter/sequencer that shares one 8-input one-hot-encoded resource among 8 requesters.
- Emits a registered one-hot grant plus its 3-bit binary index, using the same 8-to-3 index mapping as the team's encoder (bit0->000 ... bit7->111).
- The grant is held until the owner signals done, drops its request, or hits a hold timeout.
- Sits between requester agents and the shared encoder/resource; the one-hot gnt is always a legal encoder input.

Parameters:
- MAX_HOLD, 16: max cycles a grant is held before forced release; 0 disables timeout; legal 0..255.
- CNT_W, 8: width of internal hold counter; must satisfy MAX_HOLD < 2**CNT_W.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- req  input  8  request vector, bit i = requester i.
- done  input  1  current owner releases grant (1-cycle pulse or level).
- gnt  output  8  registered one-hot grant; all-zero when no owner.
- gnt_idx  output  3  binary index of gnt bit (bit0->0 ... bit7->7).
- gnt_valid  output  1  high while gnt is non-zero.
- timeout  output  1  1-cycle pulse on forced release.

Behaviour:
- One clock (clk); reset synchronous, active-high (rst), sampled on rising clk; overrides all other inputs.
- Reset values: gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, timeout=0, ptr=3'd0, hold_cnt=0, state=IDLE.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, OWN.
- IDLE, req==0: stay IDLE; outputs hold reset/idle values, except gnt_idx keeps the last owner index.
- IDLE, req!=0: winner = first set bit of req scanning circularly from ptr upward (ptr, ptr+1, ..., 7, 0, ..., ptr-1).
  - Next edge: gnt=onehot(winner), gnt_idx=winner, gnt_valid=1, hold_cnt=0, state=OWN.
  - Latency req->gnt = 1 clock.
- OWN, hold_cnt increments each cycle (saturates, no wrap). Release when any of:
  - (a) done=1;
  - (b) req[gnt_idx]=0;
  - (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1.
- Effects of release, next edge:
  - gnt=0, gnt_valid=0, state=IDLE;
  - ptr = gnt_idx+1 mod 8 (7 wraps to 0);
  - timeout=1 only if (c) is the sole cause; timeout otherwise 0.
- Simultaneous release causes: done or req drop takes precedence; no timeout pulse.
- Grant spacing: minimum one IDLE cycle (gnt=0) between consecutive grants; never two bits of gnt high; no overlap.
- Max hold: a grant lasts at most MAX_HOLD cycles when timeout is enabled.
- Fairness: a continuously requesting requester is granted within 7 other grants.
- Ignored inputs: done in IDLE is ignored; req changes on non-owner bits during OWN have no effect until the next IDLE arbitration.
- Reset mid-grant: gnt drops to 0 on the reset edge; ptr returns to 0.
- gnt_idx is always the encoder mapping of gnt when gnt_valid=1.

Test Plan:
- Reset: rst=1 for 2 cycles with req=8'hFF -> gnt=00, gnt_valid=0, gnt_idx=0, timeout=0 throughout.
- Single request: after reset, req=8'h10 at cycle 0 -> gnt=8'h10, gnt_idx=4, gnt_valid=1 at cycle 1; done pulse at cycle 3 -> gnt=00 at cycle 4, ptr=5.
- Rotation: req=8'hFF held, done pulsed the cycle after each grant -> gnt_idx sequence 0,1,2,...,7,0 with one gnt=00 cycle between each; wrap 7->0 confirmed.
- Circular scan: ptr=5 (after granting 4), req=8'h09 -> grant bit0 (gnt=01, gnt_idx=0), not bit3; then next grant with req=8'h09 -> bit3.
- Timeout: MAX_HOLD=4, req=8'h04 held, done=0 -> gnt=04 for exactly 4 cycles, then gnt=00 with timeout=1 for one cycle, next grant to bit2 again; done asserted on the 4th hold cycle -> timeout stays 0.
- Reset mid-grant and request drop: owner bit6 deasserts req[6] -> release next edge, ptr=7; separately, rst during OWN -> gnt=00 next edge, next arbitration starts from bit0.
